// File: rtl/maj_net_sequencer_if.sv
// Host-side bundle for maj_net_sequencer: program load, run control and truth-table stream.
interface maj_net_sequencer_if;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [17:0] prog_data;
  logic [4:0]  num_nodes;
  logic        out_inv;
  logic        start;
  logic        busy;
  logic        done;
  logic        tt_valid;
  logic        tt_ready;
  logic [31:0] tt_data;
  logic [1:0]  tt_idx;

  modport master (
    output prog_we, prog_addr, prog_data, num_nodes, out_inv, start, tt_ready,
    input  busy, done, tt_valid, tt_data, tt_idx
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, num_nodes, out_inv, start, tt_ready,
    output busy, done, tt_valid, tt_data, tt_idx
  );
endinterface

// File: rtl/maj_net_sequencer.sv
// Time-multiplexed majority-network evaluator: one MAJ3 per node per minterm over all
// 128 assignments of x0..x6, streamed out as four 32-bit truth-table words.
module maj_net_sequencer #(
  parameter int NODE_MAX = 16,
  parameter int SEL_W    = 5
) (
  input logic clk,
  input logic rst,
  maj_net_sequencer_if.slave bus
);

  localparam int PW = 3 * (SEL_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_EMIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [6:0]          m_q, m_d;
  logic [3:0]          k_q, k_d;
  logic [4:0]          n_q, n_d;
  logic                out_inv_q, out_inv_d;
  logic [NODE_MAX-1:0] w_q, w_d;
  logic [31:0]         word_q, word_d;
  logic [PW-1:0]       prog_mem_q [NODE_MAX];
  logic [PW-1:0]       prog_mem_d [NODE_MAX];

  logic [PW-1:0] instr;
  logic          op_a, op_b, op_c, node_val;

  // Node results from this or later nodes read as 0, so stale w from the previous minterm never leaks.
  function automatic logic operand(input logic [SEL_W:0] fld, input logic [6:0] m,
                                   input logic [NODE_MAX-1:0] w, input logic [3:0] k);
    logic [SEL_W-1:0] sel;
    logic [3:0]       j;
    logic             v;
    sel = fld[SEL_W-1:0];
    j   = sel[3:0] - 4'd8;
    v   = 1'b0;
    if (sel >= 5'd1 && sel <= 5'd7) begin
      v = m[sel[2:0] - 3'd1];
    end else if (sel >= 5'd8 && sel <= 5'd23) begin
      if (j < k) v = w[j];
    end
    return v ^ fld[SEL_W];
  endfunction

  assign instr    = prog_mem_q[k_q];
  assign op_a     = operand(instr[5:0],   m_q, w_q, k_q);
  assign op_b     = operand(instr[11:6],  m_q, w_q, k_q);
  assign op_c     = operand(instr[17:12], m_q, w_q, k_q);
  assign node_val = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    k_d        = k_q;
    n_d        = n_q;
    out_inv_d  = out_inv_q;
    w_d        = w_q;
    word_d     = word_q;
    prog_mem_d = prog_mem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.prog_we) prog_mem_d[bus.prog_addr] = bus.prog_data;
        if (bus.start && bus.num_nodes != 5'd0 && bus.num_nodes <= 5'd16) begin
          state_d   = S_EVAL;
          m_d       = 7'd0;
          k_d       = 4'd0;
          n_d       = bus.num_nodes;
          out_inv_d = bus.out_inv;
        end
      end
      S_EVAL: begin
        w_d[k_q] = node_val;
        if ({1'b0, k_q} == n_q - 5'd1) begin
          word_d[m_q[4:0]] = node_val ^ out_inv_q;
          k_d = 4'd0;
          if (m_q[4:0] == 5'd31) state_d = S_EMIT;
          else                   m_d = m_q + 7'd1;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_EMIT: begin
        if (bus.tt_ready) begin
          if (m_q[6:5] == 2'd3) begin
            state_d = S_DONE;
          end else begin
            m_d     = m_q + 7'd1;
            k_d     = 4'd0;
            state_d = S_EVAL;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= 7'd0;
      k_q       <= 4'd0;
      n_q       <= 5'd0;
      out_inv_q <= 1'b0;
      w_q       <= '0;
      word_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      k_q       <= k_d;
      n_q       <= n_d;
      out_inv_q <= out_inv_d;
      w_q       <= w_d;
      word_q    <= word_d;
    end
  end

  // Program storage deliberately survives reset.
  always_ff @(posedge clk) begin
    prog_mem_q <= prog_mem_d;
  end

  assign bus.busy     = (state_q == S_EVAL) || (state_q == S_EMIT);
  assign bus.done     = (state_q == S_DONE);
  assign bus.tt_valid = (state_q == S_EMIT);
  assign bus.tt_data  = (state_q == S_EMIT) ? word_q : 32'd0;
  assign bus.tt_idx   = (state_q == S_EMIT) ? m_q[6:5] : 2'd0;

endmodule

// File: tb/tb_maj_net_sequencer.sv
// Self-checking bench for maj_net_sequencer against a per-minterm software model of the network.
module tb_maj_net_sequencer;

  logic clk;
  logic rst;
  maj_net_sequencer_if bus();

  maj_net_sequencer #(.NODE_MAX(16), .SEL_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [17:0] model_prog [16];

  logic [31:0] cap_data [4];
  logic [1:0]  cap_idx  [4];
  int          cap_nwords;
  int          cap_first_valid;
  int          cap_done_cyc;
  bit          cap_timeout;
  bit          cap_stall_ok;
  bit          cap_busy_ok;
  logic        cap_done_busy;
  bit          cap_done_width_ok;

  function automatic logic [17:0] enc(input logic inv_a, input logic [4:0] sel_a,
                                      input logic inv_b, input logic [4:0] sel_b,
                                      input logic inv_c, input logic [4:0] sel_c);
    return {inv_c, sel_c, inv_b, sel_b, inv_a, sel_a};
  endfunction

  // Reference: re-evaluates the whole network from scratch for each minterm.
  function automatic logic [127:0] model_tt(input int n, input logic inv);
    logic [127:0] tt;
    logic [15:0]  wv;
    logic [5:0]   f;
    int s, v, cnt;
    tt = '0;
    for (int m = 0; m < 128; m++) begin
      wv = '0;
      for (int k = 0; k < n; k++) begin
        cnt = 0;
        for (int o = 0; o < 3; o++) begin
          f = model_prog[k][6*o +: 6];
          s = int'(f[4:0]);
          v = 0;
          if (s >= 1 && s <= 7) v = (m >> (s - 1)) & 1;
          else if (s >= 8 && s <= 23 && (s - 8) < k) v = int'(wv[s-8]);
          if (f[5]) v = 1 - v;
          cnt += v;
        end
        wv[k] = (cnt >= 2);
      end
      tt[m] = wv[n-1] ^ inv;
    end
    return tt;
  endfunction

  task automatic load_node(input logic [3:0] addr, input logic [17:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    model_prog[addr] = data;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Starts a run and records the stream; cycle 1 is the first cycle after start is sampled.
  task automatic run_capture(input logic [4:0] n, input logic inv, input int stall_word,
                             input int stall_len, input bit rand_ready, input bit we_mid);
    int cyc;
    int stall_left;
    logic [31:0] held_data;
    logic [1:0]  held_idx;
    cap_nwords = 0; cap_first_valid = -1; cap_done_cyc = -1; cap_timeout = 0;
    cap_stall_ok = 1; cap_busy_ok = 1; cap_done_busy = 1'b1; cap_done_width_ok = 0;
    held_data = '0; held_idx = '0;
    for (int i = 0; i < 4; i++) begin cap_data[i] = '0; cap_idx[i] = '0; end
    @(negedge clk);
    bus.num_nodes = n; bus.out_inv = inv; bus.start = 1'b1; bus.tt_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.num_nodes = ~n; bus.out_inv = ~inv;
    stall_left = stall_len;
    cyc = 1;
    while (cap_done_cyc < 0 && cyc < 6000) begin
      bus.prog_we   = we_mid && (cyc == 5);
      bus.prog_addr = 4'd0;
      bus.prog_data = '1;
      bus.start     = we_mid && (cyc == 7);
      if (bus.done) begin
        cap_done_cyc  = cyc;
        cap_done_busy = bus.busy;
      end else begin
        if (!bus.busy) cap_busy_ok = 0;
        if (bus.tt_valid) begin
          if (cap_first_valid < 0) cap_first_valid = cyc;
          if (cap_nwords == stall_word && stall_left > 0) begin
            if (stall_left == stall_len) begin
              held_data = bus.tt_data; held_idx = bus.tt_idx;
            end else if (bus.tt_data !== held_data || bus.tt_idx !== held_idx) begin
              cap_stall_ok = 0;
            end
            bus.tt_ready = 1'b0;
            stall_left--;
          end else if (rand_ready && $urandom_range(0, 1) == 0) begin
            bus.tt_ready = 1'b0;
          end else begin
            bus.tt_ready = 1'b1;
            if (cap_nwords < 4) begin
              cap_data[cap_nwords] = bus.tt_data;
              cap_idx[cap_nwords]  = bus.tt_idx;
            end
            cap_nwords++;
          end
        end else begin
          bus.tt_ready = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.tt_ready = 1'b0; bus.prog_we = 1'b0; bus.start = 1'b0;
    if (cap_done_cyc < 0) cap_timeout = 1;
    cap_done_width_ok = !bus.done && !bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.tt_valid, bus.tt_data, bus.tt_idx} !== 37'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b valid=%b data=%h idx=%0d required all 0",
               bus.busy, bus.done, bus.tt_valid, bus.tt_data, bus.tt_idx);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.tt_valid} !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b valid=%b required 000",
               bus.busy, bus.done, bus.tt_valid);
    end
  endtask

  task automatic test_basic();
    logic [127:0] exp_tt;
    load_node(4'd0, enc(1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3));
    exp_tt = model_tt(1, 1'b0);
    run_capture(5'd1, 1'b0, -1, 0, 1'b0, 1'b0);
    tests_run++;
    if (cap_timeout || cap_nwords != 4) begin
      tests_failed++;
      $display("[TB] FAIL basic_completion: got timeout=%0d words=%0d required 0 and 4", cap_timeout, cap_nwords);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_data[i] !== 32'hE8E8E8E8 || cap_data[i] !== exp_tt[32*i +: 32]) begin
        tests_failed++;
        $display("[TB] FAIL basic_word%0d: got %h required %h", i, cap_data[i], 32'hE8E8E8E8);
      end
      tests_run++;
      if (cap_idx[i] !== 2'(i)) begin
        tests_failed++;
        $display("[TB] FAIL basic_idx%0d: got %0d required %0d", i, cap_idx[i], i);
      end
    end
    tests_run++;
    if (cap_first_valid != 33) begin
      tests_failed++;
      $display("[TB] FAIL basic_first_valid: got cycle %0d required 33", cap_first_valid);
    end
    tests_run++;
    if (cap_done_cyc != 133) begin
      tests_failed++;
      $display("[TB] FAIL basic_done_cycle: got cycle %0d required 133", cap_done_cyc);
    end
    tests_run++;
    if (!cap_busy_ok || cap_done_busy !== 1'b0 || !cap_done_width_ok) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy_done: got busy_ok=%0d busy_in_done=%b pulse_ok=%0d required 1 0 1",
               cap_busy_ok, cap_done_busy, cap_done_width_ok);
    end
  endtask

  task automatic test_out_inv();
    run_capture(5'd1, 1'b1, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_timeout || cap_data[i] !== 32'h17171717) begin
        tests_failed++;
        $display("[TB] FAIL out_inv_word%0d: got %h required %h", i, cap_data[i], 32'h17171717);
      end
    end
  endtask

  task automatic test_x6_const();
    logic [31:0] exp_w;
    load_node(4'd0, enc(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0));
    run_capture(5'd1, 1'b0, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_w = (i >= 2) ? 32'hFFFFFFFF : 32'h00000000;
      tests_run++;
      if (cap_timeout || cap_data[i] !== exp_w) begin
        tests_failed++;
        $display("[TB] FAIL x6_word%0d: got %h required %h", i, cap_data[i], exp_w);
      end
    end
  endtask

  task automatic test_self_ref();
    logic [127:0] exp_tt;
    load_node(4'd0, enc(1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3));
    load_node(4'd1, enc(1'b0, 5'd8, 1'b0, 5'd4, 1'b0, 5'd9));
    exp_tt = model_tt(2, 1'b0);
    run_capture(5'd2, 1'b0, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_timeout || cap_data[i] !== exp_tt[32*i +: 32] || cap_data[i] !== 32'hE800E800) begin
        tests_failed++;
        $display("[TB] FAIL self_ref_word%0d: got %h required %h", i, cap_data[i], exp_tt[32*i +: 32]);
      end
    end
    tests_run++;
    if (cap_done_cyc != 261) begin
      tests_failed++;
      $display("[TB] FAIL self_ref_done_cycle: got cycle %0d required 261", cap_done_cyc);
    end
  endtask

  task automatic test_backpressure();
    load_node(4'd0, enc(1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3));
    run_capture(5'd1, 1'b0, 1, 10, 1'b0, 1'b0);
    tests_run++;
    if (!cap_stall_ok) begin
      tests_failed++;
      $display("[TB] FAIL stall_stable: got data/idx changed during stall required stable");
    end
    tests_run++;
    if (!cap_busy_ok) begin
      tests_failed++;
      $display("[TB] FAIL stall_busy: got busy low mid-run required high");
    end
    tests_run++;
    if (cap_done_cyc != 143) begin
      tests_failed++;
      $display("[TB] FAIL stall_done_cycle: got cycle %0d required 143", cap_done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_data[i] !== 32'hE8E8E8E8 || cap_idx[i] !== 2'(i)) begin
        tests_failed++;
        $display("[TB] FAIL stall_word%0d: got %h idx %0d required %h idx %0d",
                 i, cap_data[i], cap_idx[i], 32'hE8E8E8E8, i);
      end
    end
  endtask

  task automatic test_illegal_start();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus.num_nodes = (t == 0) ? 5'd0 : 5'd17;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tt_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL illegal_start_n%0d: got busy=%b done=%b required 0 0",
                   (t == 0) ? 0 : 17, bus.busy, bus.done);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_write_during_run();
    run_capture(5'd1, 1'b0, -1, 0, 1'b0, 1'b1);
    tests_run++;
    if (cap_done_cyc != 133) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_done_cycle: got cycle %0d required 133", cap_done_cyc);
    end
    run_capture(5'd1, 1'b0, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_timeout || cap_data[i] !== 32'hE8E8E8E8) begin
        tests_failed++;
        $display("[TB] FAIL rerun_word%0d: got %h required %h", i, cap_data[i], 32'hE8E8E8E8);
      end
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus.num_nodes = 5'd1; bus.out_inv = 1'b0; bus.start = 1'b1; bus.tt_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.tt_ready = 1'b0;
    tests_run++;
    if ({bus.busy, bus.done, bus.tt_valid, bus.tt_data, bus.tt_idx} !== 37'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b valid=%b data=%h idx=%0d required all 0",
               bus.busy, bus.done, bus.tt_valid, bus.tt_data, bus.tt_idx);
    end
    run_capture(5'd1, 1'b0, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_timeout || cap_data[i] !== 32'hE8E8E8E8) begin
        tests_failed++;
        $display("[TB] FAIL abort_rerun_word%0d: got %h required %h", i, cap_data[i], 32'hE8E8E8E8);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] exp_tt;
    logic [4:0]   n;
    logic         inv;
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++) begin
        load_node(4'(a), 18'($urandom_range(0, 262143)));
      end
      n   = 5'($urandom_range(1, 16));
      inv = 1'($urandom_range(0, 1));
      exp_tt = model_tt(int'(n), inv);
      run_capture(n, inv, -1, 0, 1'b1, 1'b0);
      tests_run++;
      if (cap_timeout || cap_nwords != 4) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_completion: got timeout=%0d words=%0d required 0 and 4",
                 r, cap_timeout, cap_nwords);
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (cap_data[i] !== exp_tt[32*i +: 32] || cap_idx[i] !== 2'(i)) begin
          tests_failed++;
          $display("[TB] FAIL rand%0d_word%0d (N=%0d inv=%b): got %h idx %0d required %h idx %0d",
                   r, i, n, inv, cap_data[i], cap_idx[i], exp_tt[32*i +: 32], i);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.num_nodes = '0; bus.out_inv = 1'b0; bus.start = 1'b0; bus.tt_ready = 1'b0;
    for (int i = 0; i < 16; i++) model_prog[i] = '0;
    test_reset();
    test_basic();
    test_out_inv();
    test_x6_const();
    test_self_ref();
    test_backpressure();
    test_illegal_start();
    load_node(4'd0, enc(1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3));
    test_write_during_run();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
